// File: rtl/gbcart_bank_mapper.sv
// Game Boy cartridge bank mapper: decodes MBC-style writes, holds ROM/RAM bank
// and RAM-enable state, and opens a register window with one-cycle write strobes.
module gbcart_bank_mapper #(
  parameter int ROM_BANK_BITS  = 7,
  parameter int RAM_BANK_BITS  = 4,
  parameter int REG_WINDOW_EN  = 1,
  parameter int REG_ADDR_BITS  = 7,
  parameter int SYNC_STAGES    = 2,
  parameter int ROM_ZERO_REMAP = 1
) (
  input  logic                     sys_clock,
  input  logic                     sys_resetn,
  input  logic [15:0]              Cart_a,
  input  logic [7:0]               Cart_d,
  input  logic                     Cart_nWR,
  input  logic                     Cart_nCS,
  output logic [ROM_BANK_BITS-1:0] Rom_a,
  output logic                     Rom_nCS,
  output logic [RAM_BANK_BITS-1:0] Ram_a,
  output logic                     Ram_nCS,
  output logic                     Ram_nWE,
  output logic [RAM_BANK_BITS:0]   Ram_Bank_Id,
  output logic                     Reg_sel,
  output logic                     Reg_wr_stb,
  output logic [REG_ADDR_BITS-1:0] Reg_addr,
  output logic [7:0]               Reg_wdata
);

  localparam logic [ROM_BANK_BITS-1:0] ROM_RESET =
    (ROM_ZERO_REMAP != 0) ? ROM_BANK_BITS'(1) : '0;

  logic [SYNC_STAGES-1:0]   sync_q;
  logic [SYNC_STAGES-1:0]   vld_q;
  logic                     hist_q;
  logic                     armed_q;
  logic                     sync_last;
  logic                     wr_evt;
  logic                     ram_wren_q;
  logic [ROM_BANK_BITS-1:0] rom_bank_q;
  logic [RAM_BANK_BITS:0]   ram_bank_q;
  logic [ROM_BANK_BITS-1:0] rom_wval;
  logic [RAM_BANK_BITS:0]   ram_wval;
  logic                     reg_flag;
  logic [2:0]               region;
  logic                     win_region;
  logic                     unused_bits;

  assign sync_last  = sync_q[SYNC_STAGES-1];
  // armed_q only rises once a genuine post-reset high has reached the end of the
  // chain, so a strobe held low across reset release never looks like a fall.
  assign wr_evt     = armed_q & hist_q & ~sync_last;
  assign region     = Cart_a[15:13];
  assign win_region = (region == 3'b101);
  assign reg_flag   = ram_bank_q[RAM_BANK_BITS];
  assign unused_bits = ^Cart_a[12:0];

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      sync_q  <= '1;
      vld_q   <= '0;
      hist_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], Cart_nWR};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      hist_q  <= sync_last;
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & sync_last);
    end
  end

  always_comb begin
    rom_wval = Cart_d[ROM_BANK_BITS-1:0];
    if ((ROM_ZERO_REMAP != 0) && (rom_wval == '0)) rom_wval = ROM_BANK_BITS'(1);
    ram_wval = Cart_d[RAM_BANK_BITS:0];
    if (REG_WINDOW_EN == 0) ram_wval[RAM_BANK_BITS] = 1'b0;
  end

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      ram_wren_q <= 1'b0;
      rom_bank_q <= ROM_RESET;
      ram_bank_q <= '0;
      Reg_wr_stb <= 1'b0;
      Reg_addr   <= '0;
      Reg_wdata  <= '0;
    end else begin
      Reg_wr_stb <= 1'b0;
      if (wr_evt) begin
        case (region)
          3'b000: ram_wren_q <= (Cart_d[3:0] == 4'hA);
          3'b001: rom_bank_q <= rom_wval;
          3'b010: ram_bank_q <= ram_wval;
          3'b101: begin
            if (reg_flag && ram_wren_q) begin
              Reg_addr   <= Cart_a[REG_ADDR_BITS-1:0];
              Reg_wdata  <= Cart_d;
              Reg_wr_stb <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Rom_nCS     = Cart_a[15];
  assign Rom_a       = Cart_a[14] ? rom_bank_q : '0;
  assign Ram_a       = ram_bank_q[RAM_BANK_BITS-1:0];
  assign Ram_Bank_Id = ram_bank_q;
  assign Ram_nCS     = (win_region && !reg_flag) ? Cart_nCS : 1'b1;
  // Raw nWR so the SRAM write pulse tracks the bus rather than the synchroniser.
  assign Ram_nWE     = (ram_wren_q && !reg_flag) ? Cart_nWR : 1'b1;
  assign Reg_sel     = reg_flag & win_region & ~Cart_nCS;

endmodule

// File: tb/tb_gbcart_bank_mapper.sv
// Directed bench for gbcart_bank_mapper: vector table of bus writes with probes,
// plus hand sequences for strobe/bank latency and reset corner cases.
module tb_gbcart_bank_mapper;

  logic        sys_clock;
  logic        sys_resetn;
  logic [15:0] Cart_a;
  logic [7:0]  Cart_d;
  logic        Cart_nWR;
  logic        Cart_nCS;
  logic [6:0]  Rom_a;
  logic        Rom_nCS;
  logic [3:0]  Ram_a;
  logic        Ram_nCS;
  logic        Ram_nWE;
  logic [4:0]  Ram_Bank_Id;
  logic        Reg_sel;
  logic        Reg_wr_stb;
  logic [6:0]  Reg_addr;
  logic [7:0]  Reg_wdata;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;

  gbcart_bank_mapper dut (
    .sys_clock(sys_clock), .sys_resetn(sys_resetn),
    .Cart_a(Cart_a), .Cart_d(Cart_d), .Cart_nWR(Cart_nWR), .Cart_nCS(Cart_nCS),
    .Rom_a(Rom_a), .Rom_nCS(Rom_nCS), .Ram_a(Ram_a), .Ram_nCS(Ram_nCS),
    .Ram_nWE(Ram_nWE), .Ram_Bank_Id(Ram_Bank_Id), .Reg_sel(Reg_sel),
    .Reg_wr_stb(Reg_wr_stb), .Reg_addr(Reg_addr), .Reg_wdata(Reg_wdata)
  );

  // clock/reset block
  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  always @(negedge sys_clock) if (Reg_wr_stb) stb_cnt++;

  typedef struct {
    logic [15:0] wa;
    logic [7:0]  wd;
    logic        nwe_low;
    logic [15:0] pa;
    logic [6:0]  rom_a;
    logic [3:0]  ram_a;
    logic [4:0]  bank;
    logic        ram_ncs;
    logic        reg_sel;
    int          stb;
    logic [6:0]  raddr;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one bus write with nWR low long enough for the register to update
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, output logic nwe_low);
    @(posedge sys_clock); #1;
    Cart_a   = a;
    Cart_d   = d;
    Cart_nCS = (a[15:13] != 3'b101);
    Cart_nWR = 1'b0;
    repeat (6) @(posedge sys_clock);
    #1 nwe_low = Ram_nWE;
    Cart_nWR = 1'b1;
    repeat (6) @(posedge sys_clock);
    #1 Cart_nCS = 1'b1;
  endtask

  initial begin
    logic nwe;
    int   s0;

    vecs[0]  = '{16'h0000, 8'h0A, 1'b0, 16'hA000, 7'h00, 4'h0, 5'h00, 1'b0, 1'b0, 0, 7'h00, 8'h00};
    vecs[1]  = '{16'h4000, 8'h03, 1'b0, 16'hA000, 7'h00, 4'h3, 5'h03, 1'b0, 1'b0, 0, 7'h00, 8'h00};
    vecs[2]  = '{16'h2000, 8'h00, 1'b0, 16'h4000, 7'h01, 4'h3, 5'h03, 1'b1, 1'b0, 0, 7'h00, 8'h00};
    vecs[3]  = '{16'h2000, 8'hFF, 1'b0, 16'h7FFF, 7'h7F, 4'h3, 5'h03, 1'b1, 1'b0, 0, 7'h00, 8'h00};
    vecs[4]  = '{16'h2000, 8'h05, 1'b0, 16'h4000, 7'h05, 4'h3, 5'h03, 1'b1, 1'b0, 0, 7'h00, 8'h00};
    vecs[5]  = '{16'h4000, 8'h10, 1'b1, 16'hA000, 7'h00, 4'h0, 5'h10, 1'b1, 1'b1, 0, 7'h00, 8'h00};
    vecs[6]  = '{16'hA012, 8'h5C, 1'b1, 16'hA012, 7'h00, 4'h0, 5'h10, 1'b1, 1'b1, 1, 7'h12, 8'h5C};
    vecs[7]  = '{16'hA07F, 8'h81, 1'b1, 16'hA07F, 7'h00, 4'h0, 5'h10, 1'b1, 1'b1, 1, 7'h7F, 8'h81};
    vecs[8]  = '{16'h0000, 8'h00, 1'b1, 16'hA000, 7'h00, 4'h0, 5'h10, 1'b1, 1'b1, 0, 7'h7F, 8'h81};
    vecs[9]  = '{16'hA012, 8'h5C, 1'b1, 16'hA012, 7'h00, 4'h0, 5'h10, 1'b1, 1'b1, 0, 7'h7F, 8'h81};
    vecs[10] = '{16'h6000, 8'h0A, 1'b1, 16'hA000, 7'h00, 4'h0, 5'h10, 1'b1, 1'b1, 0, 7'h7F, 8'h81};
    vecs[11] = '{16'hC000, 8'h0A, 1'b1, 16'h4000, 7'h05, 4'h0, 5'h10, 1'b1, 1'b0, 0, 7'h7F, 8'h81};
    vecs[12] = '{16'h0000, 8'h1A, 1'b1, 16'hA000, 7'h00, 4'h0, 5'h10, 1'b1, 1'b1, 0, 7'h7F, 8'h81};
    vecs[13] = '{16'h4000, 8'hE5, 1'b0, 16'hA000, 7'h00, 4'h5, 5'h05, 1'b0, 1'b0, 0, 7'h7F, 8'h81};
    vecs[14] = '{16'hA012, 8'h33, 1'b0, 16'hA012, 7'h00, 4'h5, 5'h05, 1'b0, 1'b0, 0, 7'h7F, 8'h81};
    vecs[15] = '{16'h3FFF, 8'h80, 1'b0, 16'h4000, 7'h01, 4'h5, 5'h05, 1'b1, 1'b0, 0, 7'h7F, 8'h81};

    // reset state
    sys_resetn = 1'b0;
    Cart_a = 16'h4000; Cart_d = 8'h00; Cart_nWR = 1'b0; Cart_nCS = 1'b0;
    repeat (3) @(posedge sys_clock);
    #1;
    check("rst_rom_a", Rom_a, 7'h01);
    check("rst_rom_ncs", Rom_nCS, 1'b0);
    check("rst_ram_nwe", Ram_nWE, 1'b1);
    check("rst_bank_id", Ram_Bank_Id, 5'h00);
    check("rst_ram_a", Ram_a, 4'h0);
    check("rst_stb", Reg_wr_stb, 1'b0);
    check("rst_reg_addr", Reg_addr, 7'h00);
    check("rst_reg_wdata", Reg_wdata, 8'h00);
    Cart_a = 16'hA000; #1;
    check("rst_reg_sel", Reg_sel, 1'b0);
    check("rst_ram_ncs", Ram_nCS, 1'b0);
    Cart_nWR = 1'b1; Cart_nCS = 1'b1;
    sys_resetn = 1'b1;
    repeat (5) @(posedge sys_clock);

    // vector table
    for (int i = 0; i < 16; i++) begin
      s0 = stb_cnt;
      do_write(vecs[i].wa, vecs[i].wd, nwe);
      check($sformatf("v%0d_nwe_low", i), nwe, vecs[i].nwe_low);
      check($sformatf("v%0d_stb", i), stb_cnt - s0, vecs[i].stb);
      Cart_a = vecs[i].pa; Cart_nCS = 1'b0; #2;
      check($sformatf("v%0d_rom_a", i), Rom_a, vecs[i].rom_a);
      check($sformatf("v%0d_ram_a", i), Ram_a, vecs[i].ram_a);
      check($sformatf("v%0d_bank", i), Ram_Bank_Id, vecs[i].bank);
      check($sformatf("v%0d_ram_ncs", i), Ram_nCS, vecs[i].ram_ncs);
      check($sformatf("v%0d_reg_sel", i), Reg_sel, vecs[i].reg_sel);
      check($sformatf("v%0d_reg_addr", i), Reg_addr, vecs[i].raddr);
      check($sformatf("v%0d_reg_wdata", i), Reg_wdata, vecs[i].rdata);
      Cart_nCS = 1'b1;
    end

    // strobe latency: high only in cycle SYNC_STAGES+1 after the falling edge
    do_write(16'h4000, 8'h10, nwe);
    s0 = stb_cnt;
    @(posedge sys_clock); #1;
    Cart_a = 16'hA055; Cart_d = 8'hC3; Cart_nCS = 1'b0; Cart_nWR = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge sys_clock); #1;
      check($sformatf("lat_stb_k%0d", k), Reg_wr_stb, (k == 3));
      if (k == 3) begin
        check("lat_reg_addr", Reg_addr, 7'h55);
        check("lat_reg_wdata", Reg_wdata, 8'hC3);
      end
    end
    Cart_nWR = 1'b1;
    repeat (6) @(posedge sys_clock);
    #1 Cart_nCS = 1'b1;
    check("lat_stb_total", stb_cnt - s0, 1);

    // bank register latency
    @(posedge sys_clock); #1;
    Cart_a = 16'h4000; Cart_d = 8'h02; Cart_nWR = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge sys_clock); #1;
      check($sformatf("bank_lat_k%0d", k), Ram_Bank_Id, (k == 3) ? 5'h02 : 5'h10);
    end
    Cart_nWR = 1'b1;
    repeat (6) @(posedge sys_clock);

    // nWR held low across reset release: no event
    #1 sys_resetn = 1'b0;
    Cart_a = 16'h4000; Cart_d = 8'h07; Cart_nWR = 1'b0;
    repeat (2) @(posedge sys_clock);
    #1 sys_resetn = 1'b1;
    repeat (8) @(posedge sys_clock);
    #1 check("hold_low_bank", Ram_Bank_Id, 5'h00);
    Cart_nWR = 1'b1;
    repeat (8) @(posedge sys_clock);
    #1 check("hold_rise_bank", Ram_Bank_Id, 5'h00);
    do_write(16'h4000, 8'h06, nwe);
    check("rearm_bank", Ram_Bank_Id, 5'h06);

    // reset with a register write pending in the chain
    do_write(16'h0000, 8'h0A, nwe);
    do_write(16'h4000, 8'h10, nwe);
    s0 = stb_cnt;
    @(posedge sys_clock); #1;
    Cart_a = 16'hA012; Cart_d = 8'h5C; Cart_nCS = 1'b0; Cart_nWR = 1'b0;
    repeat (2) @(posedge sys_clock);
    #1 sys_resetn = 1'b0;
    repeat (2) @(posedge sys_clock);
    #1 sys_resetn = 1'b1;
    repeat (4) @(posedge sys_clock);
    #1 Cart_nWR = 1'b1;
    repeat (8) @(posedge sys_clock);
    #1;
    check("midrst_stb", stb_cnt - s0, 0);
    check("midrst_reg_addr", Reg_addr, 7'h00);
    check("midrst_reg_wdata", Reg_wdata, 8'h00);
    check("midrst_bank", Ram_Bank_Id, 5'h00);
    check("midrst_ram_nwe", Ram_nWE, 1'b1);
    Cart_a = 16'h4000; #1;
    check("midrst_rom_a", Rom_a, 7'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
